// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage: FSM encoding, widths and
// the alignment helper used to screen data-memory accesses.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W      = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A word access must have its two low address bits clear.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus.
//   req is held high by the stage while an access is outstanding, together with
//   stable we/addr/wdata; the memory answers with ack=1 for exactly the cycle in
//   which the access completes, with rdata valid in that same cycle. A request
//   may be withdrawn without an ack (timeout abort or reset), so the memory side
//   must tolerate a dropped request.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_wb_stage_timer.sv
// Wait-cycle counter for an outstanding memory access. Kept apart from the FSM
// so the abort threshold lives in one place.
module mem_wb_stage_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;

  // Count unanswered request cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: performs the data-memory access for the instruction leaving
// EX/MEM, stalls upstream while the access is outstanding, and registers the
// write-back result. Misaligned and timed-out accesses raise sticky flags.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite_MEM,
  input  logic              memToReg_MEM,
  input  logic              memWrite_MEM,
  input  logic              enable_MEM,
  input  logic [DATA_W-1:0] ALUresult_MEM,
  input  logic [REG_W-1:0]  writeReg_MEM,
  input  logic [DATA_W-1:0] editData_MEM,
  output logic              stall_MEM,
  mem_wb_stage_if.master    dmem,
  output logic              regWrite_WB,
  output logic [REG_W-1:0]  writeReg_WB,
  output logic [DATA_W-1:0] writeData_WB,
  output logic              bus_err,
  output logic              misalign_err,
  output state_t            dbg_state
);

  state_t state_q, state_d;

  // Holding copies of the access, used for the whole WAIT period.
  logic [DATA_W-1:0] h_addr, h_wdata;
  logic              h_we, h_m2r, h_rw;
  logic [REG_W-1:0]  h_reg;

  // Completion sources: live fields in IDLE (zero-wait), held fields in WAIT.
  logic [DATA_W-1:0] c_addr;
  logic              c_we, c_m2r, c_rw;
  logic [REG_W-1:0]  c_reg;

  logic              mem_op;
  logic              req, we, stall;
  logic [DATA_W-1:0] addr, wdata;
  logic              capture, complete, bubble, pass;
  logic              set_mis, set_bus;
  logic              t_clear, t_en, t_expired;

  assign mem_op = enable_MEM | memWrite_MEM;

  mem_wb_stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (t_clear),
    .enable  (t_en),
    .expired (t_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, bus drive, stall and write-back control.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    we       = memWrite_MEM;
    addr     = ALUresult_MEM;
    wdata    = editData_MEM;
    stall    = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    bubble   = 1'b0;
    pass     = 1'b0;
    set_mis  = 1'b0;
    set_bus  = 1'b0;
    t_clear  = 1'b0;
    t_en     = 1'b0;
    c_addr   = ALUresult_MEM;
    c_we     = memWrite_MEM;
    c_m2r    = memToReg_MEM;
    c_rw     = regWrite_MEM;
    c_reg    = writeReg_MEM;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          pass    = 1'b1;
          t_clear = 1'b1;
        end else if (is_misaligned(ALUresult_MEM[1:0])) begin
          set_mis = 1'b1;
          bubble  = 1'b1;
          t_clear = 1'b1;
        end else begin
          req     = 1'b1;
          capture = 1'b1;
          if (dmem.ack) begin
            complete = 1'b1;
            t_clear  = 1'b1;
          end else begin
            stall   = 1'b1;
            bubble  = 1'b1;
            t_en    = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req    = 1'b1;
        we     = h_we;
        addr   = h_addr;
        wdata  = h_wdata;
        c_addr = h_addr;
        c_we   = h_we;
        c_m2r  = h_m2r;
        c_rw   = h_rw;
        c_reg  = h_reg;
        if (dmem.ack) begin
          complete = 1'b1;
          t_clear  = 1'b1;
          state_d  = ST_IDLE;
        end else if (t_expired) begin
          set_bus = 1'b1;
          bubble  = 1'b1;
          t_clear = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          t_en   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // No request or stall may escape while reset is asserted.
    if (!rst_n) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = we;
  assign dmem.addr  = addr;
  assign dmem.wdata = wdata;
  assign stall_MEM  = stall;
  assign dbg_state  = state_q;

  // Capture the access when it is launched from IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_addr  <= '0;
      h_wdata <= '0;
      h_we    <= 1'b0;
      h_m2r   <= 1'b0;
      h_rw    <= 1'b0;
      h_reg   <= '0;
    end else if (capture) begin
      h_addr  <= ALUresult_MEM;
      h_wdata <= editData_MEM;
      h_we    <= memWrite_MEM;
      h_m2r   <= memToReg_MEM;
      h_rw    <= regWrite_MEM;
      h_reg   <= writeReg_MEM;
    end
  end

  // MEM/WB register: ALU pass-through, access completion, or bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite_WB  <= 1'b0;
      writeReg_WB  <= '0;
      writeData_WB <= '0;
    end else if (pass) begin
      regWrite_WB  <= regWrite_MEM;
      writeReg_WB  <= writeReg_MEM;
      writeData_WB <= ALUresult_MEM;
    end else if (complete) begin
      regWrite_WB  <= c_rw & ~c_we;
      writeReg_WB  <= c_reg;
      writeData_WB <= c_m2r ? dmem.rdata : c_addr;
    end else if (bubble) begin
      regWrite_WB  <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (set_bus) bus_err      <= 1'b1;
      if (set_mis) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a transaction-level model of the stage.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rw_mem, m2r_mem, mw_mem, en_mem;
  logic [DW-1:0] alu_mem, ed_mem;
  logic [4:0]    reg_mem;
  logic          stall_MEM, regWrite_WB, bus_err, misalign_err;
  logic [4:0]    writeReg_WB;
  logic [DW-1:0] writeData_WB;
  state_t        dbg_state;

  mem_wb_stage_if #(.DATA_W(DW)) dmem_bus ();

  mem_wb_stage #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .regWrite_MEM  (rw_mem),
    .memToReg_MEM  (m2r_mem),
    .memWrite_MEM  (mw_mem),
    .enable_MEM    (en_mem),
    .ALUresult_MEM (alu_mem),
    .writeReg_MEM  (reg_mem),
    .editData_MEM  (ed_mem),
    .stall_MEM     (stall_MEM),
    .dmem          (dmem_bus.master),
    .regWrite_WB   (regWrite_WB),
    .writeReg_WB   (writeReg_WB),
    .writeData_WB  (writeData_WB),
    .bus_err       (bus_err),
    .misalign_err  (misalign_err),
    .dbg_state     (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // One outstanding transaction at most; waited counts request cycles so far
  // that went unanswered.
  bit            m_busy;
  int            m_waited;
  logic [DW-1:0] t_addr, t_wdata;
  logic          t_we, t_m2r, t_rw;
  logic [4:0]    t_reg;
  logic          e_rw, e_bus, e_mis;
  logic [4:0]    e_reg;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_txn(input logic rw, input logic we, input logic m2r,
                            input logic [4:0] rg, input logic [DW-1:0] a,
                            input logic [DW-1:0] rd);
    e_rw   = rw && !we;
    e_reg  = rg;
    e_data = m2r ? rd : a;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 0; m_waited = 0;
      e_rw = 0; e_reg = 0; e_data = 0; e_bus = 0; e_mis = 0;
    end else if (m_busy) begin
      if (dmem_bus.ack) begin
        finish_txn(t_rw, t_we, t_m2r, t_reg, t_addr, dmem_bus.rdata);
        m_busy = 0;
      end else if (m_waited == TIMEOUT) begin
        e_bus = 1; e_rw = 0; m_busy = 0;
      end else begin
        m_waited++; e_rw = 0;
      end
    end else if (en_mem || mw_mem) begin
      if (alu_mem[1:0] != 2'b00) begin
        e_mis = 1; e_rw = 0;
      end else begin
        t_addr = alu_mem; t_wdata = ed_mem; t_we = mw_mem;
        t_m2r = m2r_mem; t_rw = rw_mem; t_reg = reg_mem;
        if (dmem_bus.ack) finish_txn(t_rw, t_we, t_m2r, t_reg, t_addr, dmem_bus.rdata);
        else begin m_busy = 1; m_waited = 1; e_rw = 0; end
      end
    end else begin
      e_rw = rw_mem; e_reg = reg_mem; e_data = alu_mem;
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic rw, input logic m2r, input logic mw, input logic en,
                        input logic [DW-1:0] a, input logic [4:0] rg, input logic [DW-1:0] ed,
                        input logic ack, input logic [DW-1:0] rd);
    rw_mem = rw; m2r_mem = m2r; mw_mem = mw; en_mem = en;
    alu_mem = a; reg_mem = rg; ed_mem = ed;
    dmem_bus.ack = ack; dmem_bus.rdata = rd;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs
  // just after the edge.
  task automatic step();
    logic          x_req, x_stall, x_we;
    logic [DW-1:0] x_addr, x_wdata;
    #2;
    x_req = 0; x_stall = 0; x_we = 0; x_addr = 0; x_wdata = 0;
    if (rst_n) begin
      if (m_busy) begin
        x_req = 1; x_we = t_we; x_addr = t_addr; x_wdata = t_wdata;
        x_stall = !dmem_bus.ack && (m_waited < TIMEOUT);
      end else if ((en_mem || mw_mem) && alu_mem[1:0] == 2'b00) begin
        x_req = 1; x_we = mw_mem; x_addr = alu_mem; x_wdata = ed_mem;
        x_stall = !dmem_bus.ack;
      end
    end
    chk("dmem_req", dmem_bus.req, x_req);
    chk("stall_MEM", stall_MEM, x_stall);
    if (x_req) begin
      chk("dmem_we", dmem_bus.we, x_we);
      chk("dmem_addr", dmem_bus.addr, x_addr);
      chk("dmem_wdata", dmem_bus.wdata, x_wdata);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("regWrite_WB", regWrite_WB, e_rw);
    if (e_rw) begin
      chk("writeReg_WB", writeReg_WB, e_reg);
      chk("writeData_WB", writeData_WB, e_data);
    end
    chk("bus_err", bus_err, e_bus);
    chk("misalign_err", misalign_err, e_mis);
    chk("state", dbg_state, m_busy ? ST_WAIT : ST_IDLE);
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_busy = 0; m_waited = 0;
    rst_n = 0;
    idle_in();
    step(); step();
    chk("rst_writeData", writeData_WB, 0);
    chk("rst_writeReg", writeReg_WB, 0);
    rst_n = 1;

    // ALU op passes straight through
    set_in(1, 0, 0, 0, 32'h0000_00AA, 5, 0, 0, 0); step();
    chk("alu_data", writeData_WB, 32'hAA);
    chk("alu_reg", writeReg_WB, 5);

    // zero-wait load
    set_in(1, 1, 0, 1, 32'h100, 7, 0, 1, 32'hDEADBEEF); step();
    chk("ld0_data", writeData_WB, 32'hDEADBEEF);
    chk("ld0_rw", regWrite_WB, 1);

    // store acknowledged on its 3rd request cycle; inputs wander meanwhile
    set_in(1, 0, 1, 0, 32'h204, 3, 32'h1234, 0, 0); step();
    set_in(1, 1, 0, 1, 32'h300, 9, 32'h5555, 0, 0); step();
    dmem_bus.ack = 1; step();
    chk("st_rw", regWrite_WB, 0);

    // misaligned load, then an aligned load acknowledged one cycle late
    set_in(1, 1, 0, 1, 32'h102, 9, 0, 0, 0); step();
    chk("mis_flag", misalign_err, 1);
    set_in(1, 1, 0, 1, 32'h108, 10, 0, 0, 0); step();
    set_in(1, 1, 0, 1, 32'h108, 10, 0, 1, 32'hCAFE_0001); step();
    chk("ld1_data", writeData_WB, 32'hCAFE_0001);

    // timeout, then a late ack with nothing outstanding
    set_in(1, 1, 0, 1, 32'h200, 4, 0, 0, 0);
    repeat (TIMEOUT + 1) step();
    chk("to_flag", bus_err, 1);
    set_in(0, 0, 0, 0, 32'h40, 2, 0, 1, 32'h1111_2222); step(); step();

    // reset during the 2nd WAIT cycle, then a fresh load
    set_in(1, 1, 0, 1, 32'h400, 6, 0, 0, 0); step(); step();
    rst_n = 0; step();
    rst_n = 1; idle_in(); step();
    set_in(1, 1, 0, 1, 32'h404, 8, 0, 1, 32'h0BAD_F00D); step();
    chk("rst_ld_data", writeData_WB, 32'h0BAD_F00D);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] a;
      int kind;
      kind = $urandom_range(0, 7);
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             kind == 5 || kind == 7, kind == 4 || kind == 6 || kind == 7,
             a, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 2) == 0, $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
